// File: rtl/spi_slave_frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI frame slave and any
//                controller-side code talking to it.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BYTE_W          = 8;
    localparam int SPI_N_WORDS_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } spi_state_e;

endpackage
`default_nettype wire

// File: rtl/spi_slave_frame_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_frame_if
//  Description : SPI pins plus the parallel byte-side bus of the frame slave.
//                slave modport  : seen by spi_slave_frame
//                master modport : seen by the SPI master / byte-side user
//  Signals     : SCLK, MOSI, SS (active-low), MISO       - SPI mode 0 pins
//                tx_data[N_WORDS] / rx_data[N_WORDS]      - bytes, index 0 first
//                byte_valid, byte_count, frame_done,
//                overflow, frame_err                      - status
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_slave_frame_if
    import spi_pkg::*;
#(
    parameter int N_WORDS = SPI_N_WORDS_DEFAULT
);

    logic [N_WORDS-1:0][SPI_BYTE_W-1:0] tx_data;
    logic [N_WORDS-1:0][SPI_BYTE_W-1:0] rx_data;
    logic                               byte_valid;
    logic [2:0]                         byte_count;
    logic                               frame_done;
    logic                               overflow;
    logic                               frame_err;
    logic                               SCLK;
    logic                               MOSI;
    logic                               SS;
    logic                               MISO;

    modport slave (
        input  tx_data, SCLK, MOSI, SS,
        output rx_data, byte_valid, byte_count, frame_done, overflow,
               frame_err, MISO
    );

    modport master (
        output tx_data, SCLK, MOSI, SS,
        input  rx_data, byte_valid, byte_count, frame_done, overflow,
               frame_err, MISO
    );

endinterface
`default_nettype wire

// File: rtl/spi_slave_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync
//  Description : N-flop synchronizer for one asynchronous input bit.
//  Ports       : clk  - system clock
//                rst  - asynchronous active-low reset (loads RESET_VAL)
//                d_i  - asynchronous input
//                q_o  - synchronized output
//  Revision    : 1.0  initial release
// ============================================================================
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d_i,
    output logic      q_o
);

    // Fewer than two flops is not a synchronizer; clamp silently.
    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= {DEPTH{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d_i};
        end
    end

    assign q_o = sync_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/spi_slave_frame.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_frame
//  Description : SPI mode 0 (MSB first) slave capturing up to N_WORDS bytes
//                per SS-low frame and returning tx_data bytes on MISO.
//                All SPI pins are oversampled by clk (clk >= 8x SCLK).
//  Ports       : clk  - system clock
//                rst  - asynchronous active-low reset
//                bus  - spi_slave_frame_if.slave (SPI pins + byte bus)
//  Config      : SPI_SLAVE_FRAME_ERR_EN - when defined, frame_err pulses with
//                frame_done if SS rises in the middle of a byte; otherwise
//                frame_err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_frame
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_WORDS     = SPI_N_WORDS_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst,
    spi_slave_frame_if.slave   bus
);

    logic sclk_s, mosi_s, ss_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk (clk), .rst (rst), .d_i (bus.SCLK), .q_o (sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk (clk), .rst (rst), .d_i (bus.MOSI), .q_o (mosi_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk (clk), .rst (rst), .d_i (bus.SS), .q_o (ss_s)
    );

    // ------------------------------------------------------------------
    // Edge detection and post-reset arming.
    // The synchronizer reset value of SS is 1, so an SS pin already low at
    // reset release would look like a falling edge once the pipeline
    // flushes. ready_q marks when the synchronized value is real, and a
    // frame may only start after SS has been genuinely observed high.
    // ------------------------------------------------------------------
    logic                   sclk_dly_q;
    logic                   ss_dly_q;
    logic [SYNC_STAGES:0]   ready_q;
    logic                   armed_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_dly_q <= 1'b0;
            ss_dly_q   <= 1'b1;
            ready_q    <= '0;
            armed_q    <= 1'b0;
        end else begin
            sclk_dly_q <= sclk_s;
            ss_dly_q   <= ss_s;
            ready_q    <= {ready_q[SYNC_STAGES-1:0], 1'b1};
            if (ready_q[SYNC_STAGES] && ss_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;

    assign w_sclk_rise =  sclk_s & ~sclk_dly_q;
    assign w_sclk_fall = ~sclk_s &  sclk_dly_q;
    assign w_ss_fall   = ~ss_s   &  ss_dly_q & armed_q;
    assign w_ss_rise   =  ss_s   & ~ss_dly_q;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    spi_state_e                         state_q;
    logic [2:0]                         byte_count_q;
    logic [2:0]                         bit_cnt_q;
    logic [SPI_BYTE_W-2:0]              rx_sr_q;
    logic [SPI_BYTE_W-1:0]              tx_sr_q;
    logic                               skip_fall_q;
    logic                               ovf_pend_q;
    logic                               overflow_q;
    logic                               byte_valid_q;
    logic                               frame_done_q;
    logic [N_WORDS-1:0][SPI_BYTE_W-1:0] rx_data_q;

    logic [SPI_BYTE_W-1:0] w_rx_byte;
    logic [SPI_BYTE_W-1:0] w_tx_next;
    logic                  w_room;

    assign w_rx_byte = {rx_sr_q, mosi_s};
    assign w_room    = (int'(byte_count_q) < N_WORDS);

    // Byte for the next slot; slots beyond N_WORDS return 0x00.
    always_comb begin
        w_tx_next = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            if (int'(byte_count_q) + 1 == i) begin
                w_tx_next = bus.tx_data[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            byte_count_q <= '0;
            bit_cnt_q    <= '0;
            rx_sr_q      <= '0;
            tx_sr_q      <= '0;
            skip_fall_q  <= 1'b0;
            ovf_pend_q   <= 1'b0;
            overflow_q   <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            rx_data_q    <= '0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        state_q      <= ST_SHIFT;
                        byte_count_q <= '0;
                        bit_cnt_q    <= '0;
                        overflow_q   <= 1'b0;
                        ovf_pend_q   <= 1'b0;
                        skip_fall_q  <= 1'b0;
                        tx_sr_q      <= bus.tx_data[0];
                    end
                end

                ST_SHIFT: begin
                    // SS rising has priority over any coincident SCLK edge.
                    if (w_ss_rise) begin
                        state_q      <= ST_FINISH;
                        frame_done_q <= 1'b1;
                        overflow_q   <= ovf_pend_q;
                    end else if (w_sclk_rise) begin
                        rx_sr_q <= w_rx_byte[SPI_BYTE_W-2:0];
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_q   <= '0;
                            // The fresh MSB must survive the falling edge
                            // that closes the current bit.
                            skip_fall_q <= 1'b1;
                            if (w_room) begin
                                for (int i = 0; i < N_WORDS; i++) begin
                                    if (byte_count_q == 3'(i)) begin
                                        rx_data_q[i] <= w_rx_byte;
                                    end
                                end
                                byte_valid_q <= 1'b1;
                                byte_count_q <= byte_count_q + 3'd1;
                                tx_sr_q      <= w_tx_next;
                            end else begin
                                ovf_pend_q <= 1'b1;
                                tx_sr_q    <= '0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else if (w_sclk_fall) begin
                        if (skip_fall_q) begin
                            skip_fall_q <= 1'b0;
                        end else begin
                            tx_sr_q <= {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                end

                ST_FINISH: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_FRAME_ERR_EN
    // SS closing a frame with bits 1..7 of a byte already clocked.
    logic frame_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= (state_q == ST_SHIFT) && w_ss_rise && (bit_cnt_q != 3'd0);
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign bus.frame_err = 1'b0;
`endif

    assign bus.rx_data    = rx_data_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.byte_count = byte_count_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
    assign bus.MISO       = ~ss_s & tx_sr_q[SPI_BYTE_W-1];

endmodule
`default_nettype wire
